// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared definitions: FSM state type and default branch-offset table
package definitions;

    localparam int DEF_PC_W      = 10;
    localparam int DEF_LUT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } pc_state_t;

    // Unsigned offset magnitudes; the branch direction comes from the decoder.
    localparam logic [15:0] BR_OFFSETS [DEF_LUT_DEPTH] = '{
        16'd0, 16'd1, 16'd4, 16'd5, 16'd8, 16'd16, 16'd3, 16'd100
    };

endpackage

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - handshake, decoder/ALU flags and PC outputs of the fetch stage
interface pc_ctrl_if #(
    parameter int PC_W = 10
);
    logic            Req;
    logic            Ack;
    logic            Branch;
    logic            BranchDir;
    logic [2:0]      LutIdx;
    logic            Halt;
    logic            MemStall;
    logic [PC_W-1:0] PC;
    logic            Run;
    logic [15:0]     InstCount;

    modport master (
        output Req, Branch, BranchDir, LutIdx, Halt, MemStall,
        input  Ack, PC, Run, InstCount
    );

    modport slave (
        input  Req, Branch, BranchDir, LutIdx, Halt, MemStall,
        output Ack, PC, Run, InstCount
    );
endinterface

// File: rtl/pc_ctrl_branch_lut.sv
// rtl/pc_ctrl_branch_lut.sv - combinational ROM from the 3-bit immediate to a PC-wide offset
module branch_lut
    import definitions::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int LUT_DEPTH = DEF_LUT_DEPTH
) (
    input  logic [2:0]      i_idx,
    output logic [PC_W-1:0] o_offset
);

    // Indices beyond a shortened table read as a zero offset (self-loop).
    always_comb begin
        o_offset = '0;
        if (32'(i_idx) < LUT_DEPTH) begin
            o_offset = PC_W'(BR_OFFSETS[i_idx]);
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter, start/done handshake FSM and optional retired-instruction counter
// Optional counter enabled by defining PC_CTRL_PERF_CNT_EN; otherwise InstCount is tied to zero.
module pc_ctrl
    import definitions::*;
#(
    parameter int PC_W       = DEF_PC_W,
    parameter int START_ADDR = 0,
    parameter int LUT_DEPTH  = DEF_LUT_DEPTH
) (
    input  logic      Clk,
    input  logic      Reset,
    pc_ctrl_if.slave  bus
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
    localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

    pc_state_t       r_state;
    pc_state_t       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_offset;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_branch_lut (
        .i_idx    (bus.LutIdx),
        .o_offset (w_offset)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_pc    <= START_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Halt outranks MemStall, which outranks Branch; all PC math wraps modulo 2^PC_W.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        unique case (r_state)
            IDLE: begin
                if (bus.Req) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = START_PC;
                end
            end
            RUN: begin
                if (bus.Halt) begin
                    w_state_nxt = DONE;
                end else if (bus.MemStall) begin
                    w_state_nxt = STALL;
                end else if (bus.Branch) begin
                    w_pc_nxt = bus.BranchDir ? (r_pc - w_offset) : (r_pc + w_offset);
                end else begin
                    w_pc_nxt = r_pc + PC_ONE;
                end
            end
            STALL: begin
                w_state_nxt = RUN;
                w_pc_nxt    = r_pc + PC_ONE;
            end
            DONE: begin
                if (!bus.Req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.PC  = r_pc;
    assign bus.Run = (r_state == RUN);
    assign bus.Ack = (r_state == DONE);

`ifdef PC_CTRL_PERF_CNT_EN
    logic [15:0] r_inst_cnt;
    logic        w_retire;

    // A Halt cycle retires even if MemStall is also raised, since Halt wins.
    assign w_retire = (r_state == RUN) && (bus.Halt || !bus.MemStall);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_inst_cnt <= '0;
        end else if ((r_state == IDLE) && bus.Req) begin
            r_inst_cnt <= '0;
        end else if (w_retire && (r_inst_cnt != 16'hFFFF)) begin
            r_inst_cnt <= r_inst_cnt + 16'd1;
        end
    end

    assign bus.InstCount = r_inst_cnt;
`else
    assign bus.InstCount = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - self-checking bench for pc_ctrl with a cycle-level behavioural model
module tb_pc_ctrl;

    localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_DONE = 3;
    localparam int MEM = 1024;

    logic Clk;
    logic Reset;

    pc_ctrl_if #(.PC_W(10)) bus ();
    pc_ctrl_if #(.PC_W(10)) hbus ();

    pc_ctrl #(.PC_W(10), .START_ADDR(0), .LUT_DEPTH(8)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    pc_ctrl #(.PC_W(10), .START_ADDR(1020), .LUT_DEPTH(8)) u_dut_hi (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (hbus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;
    int m_st  = M_IDLE;
    int m_pc  = 0;
    int m_cnt = 0;
    int lut [8] = '{0, 1, 4, 5, 8, 16, 3, 100};

    function automatic int exp_cnt();
`ifdef PC_CTRL_PERF_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic void model_retire();
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
    endfunction

    // Apply one cycle of inputs, advance the reference model, and land #1 after the edge.
    task automatic step(input bit req, input bit br, input bit dir, input int idx,
                        input bit halt, input bit ms);
        bus.Req = req; bus.Branch = br; bus.BranchDir = dir;
        bus.LutIdx = 3'(idx); bus.Halt = halt; bus.MemStall = ms;
        case (m_st)
            M_IDLE: if (req) begin m_st = M_RUN; m_pc = 0; m_cnt = 0; end
            M_RUN: begin
                if (halt) begin
                    m_st = M_DONE; model_retire();
                end else if (ms) begin
                    m_st = M_STALL;
                end else begin
                    model_retire();
                    if (br && dir)  m_pc = (m_pc - lut[idx] + MEM) % MEM;
                    else if (br)    m_pc = (m_pc + lut[idx]) % MEM;
                    else            m_pc = (m_pc + 1) % MEM;
                end
            end
            M_STALL: begin m_st = M_RUN; m_pc = (m_pc + 1) % MEM; end
            default: if (!req) m_st = M_IDLE;
        endcase
        @(posedge Clk);
        #1;
    endtask

    task automatic end_program();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Req = 0; bus.Branch = 0; bus.BranchDir = 0; bus.LutIdx = 0; bus.Halt = 0; bus.MemStall = 0;
        hbus.Req = 0; hbus.Branch = 0; hbus.BranchDir = 0; hbus.LutIdx = 0; hbus.Halt = 0; hbus.MemStall = 0;
        #1 Reset = 1'b0;
        #1;
        n_vec++; if (bus.PC !== 10'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", bus.PC); end
        n_vec++; if (bus.Run !== 1'b0) begin n_err++; $display("FAIL reset_run: got %b want 0", bus.Run); end
        n_vec++; if (bus.Ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", bus.Ack); end
        n_vec++; if (bus.InstCount !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.InstCount); end
        n_vec++; if (hbus.PC !== 10'd1020) begin n_err++; $display("FAIL reset_pc_hi: got %0d want 1020", hbus.PC); end
        #1 Reset = 1'b1;
        step(0, 1, 0, 2, 0, 0);
        n_vec++; if (bus.PC !== 10'd0 || bus.Run !== 1'b0) begin n_err++; $display("FAIL idle_hold: pc %0d run %b want 0/0", bus.PC, bus.Run); end
    endtask

    task automatic test_wrap();
        hbus.Req = 1'b1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if (hbus.PC !== 10'((1020 + i) % MEM)) begin
                n_err++; $display("FAIL wrap_seq[%0d]: got %0d want %0d", i, hbus.PC, (1020 + i) % MEM);
            end
            @(posedge Clk);
            #1;
        end
        hbus.Req = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        step(1, 0, 0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0);
        n_vec++; if (bus.PC !== 10'd5) begin n_err++; $display("FAIL pre_reset_pc: got %0d want 5", bus.PC); end
        Reset = 1'b0;
        #1;
        n_vec++; if (bus.PC !== 10'd0) begin n_err++; $display("FAIL async_reset_pc: got %0d want 0", bus.PC); end
        n_vec++; if (bus.Run !== 1'b0 || bus.Ack !== 1'b0) begin n_err++; $display("FAIL async_reset_run_ack: got %b/%b want 0/0", bus.Run, bus.Ack); end
        n_vec++; if (bus.InstCount !== 16'd0) begin n_err++; $display("FAIL async_reset_cnt: got %0d want 0", bus.InstCount); end
        bus.Req = 1'b0;
        #2 Reset = 1'b1;
        m_st = M_IDLE; m_pc = 0; m_cnt = 0;
        step(0, 0, 0, 0, 0, 0);
        n_vec++; if (bus.Run !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: run %b want 0", bus.Run); end
    endtask

    task automatic test_branch();
        step(1, 0, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0, 0);
        n_vec++; if (bus.PC !== 10'd10) begin n_err++; $display("FAIL br_setup: got %0d want 10", bus.PC); end
        step(0, 1, 0, 2, 0, 0);
        n_vec++; if (bus.PC !== 10'd14) begin n_err++; $display("FAIL br_fwd: got %0d want 14", bus.PC); end
        step(0, 1, 1, 2, 0, 0);
        n_vec++; if (bus.PC !== 10'd10) begin n_err++; $display("FAIL br_back: got %0d want 10", bus.PC); end
        end_program();
        step(1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 3, 0, 0);
        n_vec++; if (bus.PC !== 10'd1022) begin n_err++; $display("FAIL br_underflow: got %0d want 1022", bus.PC); end
        step(0, 1, 0, 0, 0, 0);
        n_vec++; if (bus.PC !== 10'd1022) begin n_err++; $display("FAIL br_selfloop: got %0d want 1022", bus.PC); end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        n_vec++; if (bus.PC !== 10'd0) begin n_err++; $display("FAIL br_wrap: got %0d want 0", bus.PC); end
        end_program();
    endtask

    task automatic test_priority();
        step(1, 0, 0, 0, 0, 0);
        repeat (8) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2, 1, 1);
        n_vec++; if (bus.PC !== 10'd8) begin n_err++; $display("FAIL prio_pc: got %0d want 8", bus.PC); end
        n_vec++; if (bus.Ack !== 1'b1 || bus.Run !== 1'b0) begin n_err++; $display("FAIL prio_done: ack %b run %b want 1/0", bus.Ack, bus.Run); end
        step(0, 0, 0, 0, 0, 0);
        n_vec++; if (bus.Ack !== 1'b0) begin n_err++; $display("FAIL prio_release: ack %b want 0", bus.Ack); end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        n_vec++; if (bus.PC !== 10'd20 || bus.Run !== 1'b0) begin n_err++; $display("FAIL stall_hold: pc %0d run %b want 20/0", bus.PC, bus.Run); end
        step(0, 1, 0, 2, 1, 1);
        n_vec++; if (bus.PC !== 10'd21 || bus.Run !== 1'b1) begin n_err++; $display("FAIL stall_exit: pc %0d run %b want 21/1", bus.PC, bus.Run); end
        end_program();
    endtask

    task automatic test_handshake();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 5, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        n_vec++; if (bus.InstCount !== 16'(exp_cnt())) begin n_err++; $display("FAIL hs_count: got %0d want %0d", bus.InstCount, exp_cnt()); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0);
            n_vec++; if (bus.Ack !== 1'b1) begin n_err++; $display("FAIL hs_ack_held[%0d]: got %b want 1", i, bus.Ack); end
        end
        n_vec++; if (bus.InstCount !== 16'(exp_cnt())) begin n_err++; $display("FAIL hs_count_hold: got %0d want %0d", bus.InstCount, exp_cnt()); end
        step(0, 0, 0, 0, 0, 0);
        n_vec++; if (bus.Ack !== 1'b0) begin n_err++; $display("FAIL hs_ack_drop: got %b want 0", bus.Ack); end
        step(1, 0, 0, 0, 0, 0);
        n_vec++; if (bus.InstCount !== 16'd0 || bus.Run !== 1'b1) begin n_err++; $display("FAIL hs_restart: cnt %0d run %b want 0/1", bus.InstCount, bus.Run); end
        end_program();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 7)), $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
            n_vec++; if (bus.PC !== 10'(m_pc)) begin n_err++; $display("FAIL rnd_pc[%0d]: got %0d want %0d", i, bus.PC, m_pc); end
            n_vec++; if (bus.Run !== (m_st == M_RUN)) begin n_err++; $display("FAIL rnd_run[%0d]: got %b want %b", i, bus.Run, m_st == M_RUN); end
            n_vec++; if (bus.Ack !== (m_st == M_DONE)) begin n_err++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, bus.Ack, m_st == M_DONE); end
            n_vec++; if (bus.InstCount !== 16'(exp_cnt())) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, bus.InstCount, exp_cnt()); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_reset_mid_run();
        test_branch();
        test_priority();
        test_stall();
        test_handshake();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Fetch/sequencing stage directly downstream of the combinational ALU.
- Owns the program counter and consumes the ALU `Branch` flag (BNZL/BNZR).
- Selects the next PC from sequential, branch-offset, stall or halt conditions.
- Runs the Req/Ack start/done handshake with the testbench and gates core activity through `Run`.

Parameters:
- PC_W, 10, program counter width in bits; instruction memory depth is 2^PC_W.
- START_ADDR, 0, PC value loaded when a program starts.
- LUT_DEPTH, 8, number of branch-offset entries, indexed by the 3-bit immediate field.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  start request from the testbench.
- Ack  out  1  program done; held until Req falls.
- Branch  in  1  taken flag from the ALU (BNZL/BNZR, InputB != 0).
- BranchDir  in  1  from the decoder: 1 = BNZL (backward, subtract offset), 0 = BNZR (forward, add offset).
- LutIdx  in  3  Instruction[2:0]; selects the branch-offset entry.
- Halt  in  1  decoder flags a halt instruction.
- MemStall  in  1  decoder flags a load needing one extra cycle.
- PC  out  PC_W  current instruction address.
- Run  out  1  high only in RUN state; gates register-file and data-memory writes.
- InstCount  out  16  retired-instruction count (see Optional Feature).

Behaviour:
- Reset asserted, at any time and in any state:
  - state = IDLE, PC = START_ADDR, Ack = 0, Run = 0, InstCount = 0.
  - An in-flight program is abandoned; no partial update completes.
- States: IDLE, RUN, STALL, DONE, encoded as an enum. All transitions occur on the rising edge of Clk.
- IDLE:
  - Req = 1 → RUN, PC <= START_ADDR.
  - Otherwise stay in IDLE, PC holds.
- RUN, priority Halt > MemStall > Branch > sequential:
  - Halt: → DONE, PC holds.
  - MemStall: → STALL, PC holds.
  - Branch & BranchDir = 1: PC <= PC − LUT[LutIdx].
  - Branch & BranchDir = 0: PC <= PC + LUT[LutIdx].
  - Otherwise: PC <= PC + 1.
- STALL:
  - Exactly one cycle, then → RUN with PC <= PC + 1.
  - Branch, Halt and MemStall are ignored in STALL.
- DONE:
  - Ack = 1, Run = 0, PC holds.
  - Req = 0 → IDLE; Ack drops in the same edge's cycle.
  - Req still 1: remain in DONE. No restart without Req first deasserting.
- Req changes during RUN/STALL are ignored.
- All PC arithmetic is modulo 2^PC_W:
  - Wrap past the top of memory is silent (e.g. 1023 + 1 = 0 at PC_W = 10).
  - Backward underflow wraps (3 − 5 = 1022).
- LUT entry value 0 with Branch taken: PC holds, forming a legal self-loop.
- LUT entries are unsigned PC_W-bit magnitudes; direction comes only from BranchDir.
- Outputs are registered except Run and Ack, which decode directly from the state register.
- No combinational path from Branch to PC output within a cycle.

Optional Feature:
- Macro: PC_CTRL_PERF_CNT_EN.
- When defined, InstCount:
  - Clears to 0 on the IDLE→RUN transition.
  - Increments once per RUN cycle that does not enter STALL. The Halt cycle counts; STALL cycles do not.
  - Saturates at 16'hFFFF.
  - Holds its value in DONE.
- When undefined: InstCount is tied to 0 and no counter flops are synthesised. The port list is identical either way.

Decomposition:
- The shared package `definitions` gains:
  - `pc_state_t` enum {IDLE, RUN, STALL, DONE}.
  - Constant array `BR_OFFSETS[LUT_DEPTH]` with the default offset values, chosen per program by the team.
- Sub-module `branch_lut`: combinational ROM from LutIdx to a PC_W-bit offset, sourced from `BR_OFFSETS`.
- `pc_ctrl` instantiates one `branch_lut` and holds the FSM, the PC register and the optional counter.

Test Plan:
- Reset mid-RUN:
  - Start, step PC to 5, pulse Reset low for 3 ns between edges.
  - Required: PC = 0, Ack = 0, Run = 0 immediately, without waiting for an edge.
- Sequential and wrap (PC_W = 10, START_ADDR = 1020):
  - Run 6 cycles with no Branch/Halt.
  - Required PC sequence: 1020, 1021, 1022, 1023, 0, 1, 2.
- Branches (LUT[2] = 4):
  - At PC = 10, Branch = 1, BranchDir = 0 → next PC = 14.
  - At PC = 14, Branch = 1, BranchDir = 1 → next PC = 10.
  - At PC = 3, backward with LUT = 5 → next PC = 1022.
- Priority:
  - At PC = 8, assert Halt, MemStall and Branch together.
  - Required: DONE, PC stays 8, Ack = 1 on the next cycle.
- Stall:
  - At PC = 20, MemStall = 1 → PC is 20 for 2 cycles, then 21.
  - Branch asserted during the STALL cycle has no effect.
- Handshake and counter (PC_CTRL_PERF_CNT_EN defined):
  - Program of 5 instructions with 1 stall, Halt on the 5th.
  - Required: InstCount = 5; Ack held while Req = 1; Ack falls once Req drops; the next Req pulse restarts with InstCount = 0.
